// File: rtl/atm_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module   : atm_keypad_entry
//  Desc     : ATM front-end input stage. Latches the card account number,
//             collects a 4-digit BCD PIN from a strobed keypad (backspace,
//             cancel, enter), hands it to the ATM core with a one-cycle
//             pin_valid strobe, and counts consecutive authentication
//             failures per account so the terminal can be locked.
//             Optional inactivity timeout: define KEYPAD_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module atm_keypad_entry #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_TRIES      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        card_in,
   input  logic [3:0]  card_acc,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        auth_done,
   input  logic        auth_ok,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic        pin_valid,
   output logic [2:0]  digit_count,
   output logic [2:0]  state,
   output logic        locked,
   output logic        timeout
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_SUBMIT  = 3'd2,
      ST_WAIT    = 3'd3,
      ST_SESSION = 3'd4,
      ST_LOCKED  = 3'd5
   } state_t;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CANCEL = 4'hC;
   localparam logic [2:0] MAX_T     = 3'(MAX_TRIES);

   // Reject configurations the tries counter or timer cannot represent.
   if (TIMEOUT_CYCLES < 2 || MAX_TRIES < 1 || MAX_TRIES > 7) begin : g_param_check
      $error("atm_keypad_entry: TIMEOUT_CYCLES must be >= 2 and MAX_TRIES in 1..7");
   end

   state_t      cur;
   logic [2:0]  tries;
   logic [3:0]  last_acc;
   logic [2:0]  tries_next;
   logic        key_digit;

   assign state      = cur;
   assign tries_next = tries + 3'd1;
   assign key_digit  = (key_code <= 4'd9);

`ifdef KEYPAD_TIMEOUT_EN
   localparam int         TW         = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] timer;
`else
   // No inactivity supervision in this build: ENTRY waits indefinitely.
   assign timeout = 1'b0;
`endif

   // Main control FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur         <= ST_IDLE;
         acc_num     <= 4'd0;
         pin         <= 16'd0;
         pin_valid   <= 1'b0;
         digit_count <= 3'd0;
         locked      <= 1'b0;
         tries       <= 3'd0;
         last_acc    <= 4'd0;
`ifdef KEYPAD_TIMEOUT_EN
         timeout     <= 1'b0;
         timer       <= '0;
`endif
      end else begin
         // Pulsed outputs default low every cycle.
         pin_valid <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
         timeout   <= 1'b0;
`endif
         case (cur)
            ST_IDLE: begin
               pin         <= 16'd0;
               digit_count <= 3'd0;
               if (card_in) begin
                  acc_num <= card_acc;
                  cur     <= ST_ENTRY;
                  // A different card starts with a clean failure history.
                  if (card_acc != last_acc) begin
                     tries <= 3'd0;
                  end
`ifdef KEYPAD_TIMEOUT_EN
                  timer <= '0;
`endif
               end
            end

            ST_ENTRY: begin
               if (!card_in) begin
                  // Card removal outranks any key in the same cycle.
                  cur         <= ST_IDLE;
                  pin         <= 16'd0;
                  digit_count <= 3'd0;
               end else if (key_valid) begin
`ifdef KEYPAD_TIMEOUT_EN
                  // Any strobe, even an ignored code, counts as activity.
                  timer <= '0;
`endif
                  if (key_digit) begin
                     if (digit_count < 3'd4) begin
                        pin         <= {pin[11:0], key_code};
                        digit_count <= digit_count + 3'd1;
                     end
                  end else if (key_code == KEY_BKSP) begin
                     if (digit_count != 3'd0) begin
                        pin         <= {4'h0, pin[15:4]};
                        digit_count <= digit_count - 3'd1;
                     end
                  end else if (key_code == KEY_ENTER) begin
                     if (digit_count == 3'd4) begin
                        cur       <= ST_SUBMIT;
                        pin_valid <= 1'b1;
                     end
                  end else if (key_code == KEY_CANCEL) begin
                     cur         <= ST_IDLE;
                     pin         <= 16'd0;
                     digit_count <= 3'd0;
                  end
               end else begin
`ifdef KEYPAD_TIMEOUT_EN
                  if (timer == TIMER_LAST) begin
                     cur         <= ST_IDLE;
                     pin         <= 16'd0;
                     digit_count <= 3'd0;
                     timeout     <= 1'b1;
                  end else begin
                     timer <= timer + 1'b1;
                  end
`endif
               end
            end

            ST_SUBMIT: begin
               // pin_valid was raised on the way in; it drops this edge.
               if (!card_in) begin
                  cur         <= ST_IDLE;
                  pin         <= 16'd0;
                  digit_count <= 3'd0;
               end else begin
                  cur <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (!card_in) begin
                  // Verdict arriving with removal is discarded.
                  cur         <= ST_IDLE;
                  pin         <= 16'd0;
                  digit_count <= 3'd0;
               end else if (auth_done) begin
                  if (auth_ok) begin
                     tries <= 3'd0;
                     cur   <= ST_SESSION;
                  end else begin
                     tries    <= tries_next;
                     last_acc <= acc_num;
                     if (tries_next == MAX_T) begin
                        cur    <= ST_LOCKED;
                        locked <= 1'b1;
                     end else begin
                        cur         <= ST_ENTRY;
                        pin         <= 16'd0;
                        digit_count <= 3'd0;
`ifdef KEYPAD_TIMEOUT_EN
                        timer       <= '0;
`endif
                     end
                  end
               end
            end

            ST_SESSION: begin
               if (!card_in) begin
                  cur         <= ST_IDLE;
                  pin         <= 16'd0;
                  digit_count <= 3'd0;
               end
            end

            ST_LOCKED: begin
               // Sticky until reset; card and keys have no effect.
               locked <= 1'b1;
            end

            default: begin
               cur <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Front-end input stage for the ATM controller. It captures the account number from an inserted card and collects a 4-digit PIN from a strobed keypad, with backspace, cancel and an inactivity timeout. It presents the account number and BCD-packed PIN to the ATM core's `acc_num`/`pin` inputs with a one-cycle `pin_valid` strobe. It consumes the authentication verdict back from the ATM core and tracks consecutive failures so it can lock the terminal.

## Interface
- `TIMEOUT_CYCLES`, 1000: inactivity limit in ENTRY, in clock cycles (≥2).
- `MAX_TRIES`, 3: consecutive auth failures before lock (1..7).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `card_in` in 1: level, card present.
- `card_acc` in 4: account number read from card, valid while `card_in`=1.
- `key_valid` in 1: one-cycle key strobe.
- `key_code` in 4: 0–9 digit, 4'hA enter, 4'hB backspace, 4'hC cancel; 4'hD–4'hF ignored.
- `auth_done` in 1: one-cycle verdict strobe from the ATM core.
- `auth_ok` in 1: verdict, qualified by `auth_done`.
- `acc_num` out 4: latched account number.
- `pin` out 16: BCD PIN; first digit in [15:12] after 4 digits.
- `pin_valid` out 1: one-cycle pulse, `pin`/`acc_num` stable.
- `digit_count` out 3: digits entered (0..4).
- `state` out 3: current FSM state.
- `locked` out 1: terminal locked.
- `timeout` out 1: one-cycle pulse on inactivity abort.

## Operation
- State encodings: IDLE=0, ENTRY=1, SUBMIT=2, WAIT=3, SESSION=4, LOCKED=5. Other values go to IDLE.
- Reset (`rst`=0 at a rising edge) puts every output at 0 and the state at IDLE. It also clears the tries counter and `last_acc`.
- **IDLE**
  - `pin`=0 and `digit_count`=0.
  - `card_in`=1 latches `card_acc` into `acc_num` and moves to ENTRY.
  - If `card_acc` differs from `last_acc`, the tries counter clears.
- **ENTRY, digit key**
  - Accepted only when `digit_count`<4.
  - Effect: `pin` <= {pin[11:0], digit} and `digit_count`+1.
  - When `digit_count`=4 the digit is ignored.
- **ENTRY, other keys**
  - Backspace with `digit_count`>0: `pin` <= {4'h0, pin[15:4]} and `digit_count`−1. With `digit_count`=0 it is ignored.
  - Enter with `digit_count`=4 moves to SUBMIT. With fewer than 4 digits it is ignored.
  - Cancel returns to IDLE and clears `pin` and `digit_count`.
- **SUBMIT**: `pin_valid`=1 for exactly this cycle, then WAIT.
- **WAIT**
  - Keys are ignored.
  - `auth_done`=1 with `auth_ok`=1: tries clear, go to SESSION.
  - `auth_done`=1 with `auth_ok`=0: tries+1 and `last_acc` <= `acc_num`.
    - If the new tries count equals `MAX_TRIES`, go to LOCKED.
    - Otherwise go to ENTRY with `pin`=0 and `digit_count`=0.
- **SESSION**: holds `acc_num`/`pin` for the ATM core. Keys are ignored.
- **LOCKED**: `locked`=1. Only `rst` exits this state. Card removal and keys are ignored.
- **Card removal**: `card_in`=0 in ENTRY, SUBMIT, WAIT or SESSION goes to IDLE and clears `pin`/`digit_count`.
  - Tries are kept, so removing the card does not reset the failure count for the same account.
  - If removal and `key_valid` occur in the same cycle, removal wins.
  - If removal and `auth_done` occur in the same cycle, removal wins and the verdict is discarded.
- `auth_done` outside WAIT is ignored.

## Timing
- All outputs are registered.
- A key strobed in cycle N is reflected in `pin`/`digit_count` in cycle N+1.
- Enter sampled at edge N puts the state in SUBMIT after edge N, with `pin_valid` high in that cycle. The state is WAIT after edge N+1.
- `auth_done` is sampled in the same cycle it is asserted. The state changes at the next edge.
- The inactivity counter runs only in ENTRY.
  - It clears on entry to ENTRY and on every `key_valid`, including ignored codes.
  - When it reaches `TIMEOUT_CYCLES`−1 with no key, the next edge goes to IDLE, clears `pin`, and pulses `timeout` for one cycle.
  - A key in the terminal cycle wins over the timeout.
- Card insert to ENTRY takes 1 cycle.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined: the inactivity counter and `timeout` pulse are implemented as above.
- Not defined: no counter is synthesized, `timeout` is tied to 0, and ENTRY waits indefinitely. All other behaviour is unchanged.

## Test plan
- Insert card `card_acc`=4'd3, keys 1,2,3,4, enter → `acc_num`=3, `pin`=16'h1234, single `pin_valid` pulse, state 3.
- Keys 5,6, backspace, 7,8,9, extra 0, enter → `pin`=16'h5789 and `digit_count`=4. The extra 0 is ignored.
- With `MAX_TRIES`=3: three submissions each answered `auth_done`=1/`auth_ok`=0 → state 5, `locked`=1. Card removal keeps state 5. After `rst`=0 for one edge, all outputs are 0.
- Two failures, remove card, reinsert the same account, then one failure → LOCKED. Repeat, but reinsert a different account → ENTRY with tries at 1.
- With `KEYPAD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: insert card, one digit, then idle → `timeout` pulses 8 cycles after the key and the state returns to 0. A key at cycle 7 prevents the timeout.
- Drop `card_in` in the same cycle as enter with 4 digits → state 0, no `pin_valid` pulse.
